// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: fetch-side bus between branch resolution, instruction memory and the PC sequencer.
//   master (branch unit / imem side) drives stall, redirect_valid, redirect_target, fetch_ready, fault_clear.
//   slave (sequencer) drives virtual_pc, physical_pc, pc_plus4, fetch_valid, fault, fault_pc.
interface pc_fetch_sequencer_if #(parameter int PHYS_W = 13);
    logic              stall;
    logic              redirect_valid;
    logic [31:0]       redirect_target;
    logic              fetch_ready;
    logic              fault_clear;
    logic [31:0]       virtual_pc;
    logic [PHYS_W-1:0] physical_pc;
    logic [31:0]       pc_plus4;
    logic              fetch_valid;
    logic              fault;
    logic [31:0]       fault_pc;
    modport master (
        output stall, redirect_valid, redirect_target, fetch_ready, fault_clear,
        input  virtual_pc, physical_pc, pc_plus4, fetch_valid, fault, fault_pc
    );
    modport slave (
        input  stall, redirect_valid, redirect_target, fetch_ready, fault_clear,
        output virtual_pc, physical_pc, pc_plus4, fetch_valid, fault, fault_pc
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: holds the architectural PC, advances/redirects it and range-checks every candidate.
//   clk, rst : single clock, synchronous active-high reset
//   fetch    : slave side of pc_fetch_sequencer_if (redirect/stall/ready/clear in; PC, offer and fault status out)
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
    parameter logic [31:0] TEXT_LIMIT = 32'h0040_1fff,
    parameter int          PHYS_W     = 13
) (
    input logic                 clk,
    input logic                 rst,
    pc_fetch_sequencer_if.slave fetch
);
    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
    localparam logic [PHYS_W-1:0] RESET_PPC = PHYS_W'(RESET_PC - TEXT_BASE);
    state_t            r_state, w_state_nxt;
    logic [31:0]       r_vpc, w_vpc_nxt, r_fault_pc, w_fault_pc_nxt;
    logic [PHYS_W-1:0] r_ppc, w_ppc_nxt;
    logic [31:0]       w_plus4, w_cand;
    logic              w_take, w_legal;
    assign w_plus4 = r_vpc + 32'd4;
    // A redirect beats stall and drops the current offer; otherwise advance only on an accepted fetch.
    assign w_cand  = fetch.redirect_valid ? fetch.redirect_target : w_plus4;
    assign w_take  = fetch.redirect_valid | (~fetch.stall & fetch.fetch_ready);
    assign w_legal = (w_cand >= TEXT_BASE) && (w_cand <= TEXT_LIMIT) && (w_cand[1:0] == 2'b00);
    always_comb begin
        w_state_nxt    = r_state;
        w_vpc_nxt      = r_vpc;
        w_ppc_nxt      = r_ppc;
        w_fault_pc_nxt = r_fault_pc;
        case (r_state)
            BOOT: w_state_nxt = RUN;
            RUN: if (w_take) begin
                if (w_legal) begin
                    w_vpc_nxt = w_cand;
                    w_ppc_nxt = PHYS_W'(w_cand - TEXT_BASE);
                end else begin
                    w_state_nxt    = FAULT;
                    w_fault_pc_nxt = w_cand;
                end
            end
            FAULT: if (fetch.fault_clear) begin
                w_state_nxt = BOOT;
                w_vpc_nxt   = RESET_PC;
                w_ppc_nxt   = RESET_PPC;
            end
            default: w_state_nxt = BOOT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BOOT;
            r_vpc      <= RESET_PC;
            r_ppc      <= RESET_PPC;
            r_fault_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_vpc      <= w_vpc_nxt;
            r_ppc      <= w_ppc_nxt;
            r_fault_pc <= w_fault_pc_nxt;
        end
    end
    assign fetch.virtual_pc  = r_vpc;
    assign fetch.physical_pc = r_ppc;
    assign fetch.pc_plus4    = w_plus4;
    assign fetch.fetch_valid = (r_state == RUN);
    assign fetch.fault       = (r_state == FAULT);
    assign fetch.fault_pc    = r_fault_pc;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: vector table, directed corner sequences and random stimulus against a behavioural model.
module tb_pc_fetch_sequencer;
    localparam logic [31:0] RPC = 32'h0040_0000, TB = 32'h0040_0000, TL = 32'h0040_1fff;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    pc_fetch_sequencer_if bus ();
    pc_fetch_sequencer dut (.clk(clk), .rst(rst), .fetch(bus));
    int n_chk = 0, n_fail = 0;
    logic [31:0] m_pc = RPC, m_fpc = 0;
    bit m_boot = 1, m_fault = 0;
    typedef struct {
        bit r, s, rv; logic [31:0] t; bit rd, cl;
        logic [31:0] vpc; bit fv;
    } vec_t;
    vec_t vt[$];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic model_step(input bit r, input bit s, input bit rv, input logic [31:0] t, input bit rd, input bit cl);
        logic [31:0] c;
        if (r) begin
            m_pc = RPC; m_boot = 1; m_fault = 0; m_fpc = 0;
        end else if (m_fault) begin
            if (cl) begin m_pc = RPC; m_boot = 1; m_fault = 0; end
        end else if (m_boot) begin
            m_boot = 0;
        end else if (rv || (!s && rd)) begin
            c = rv ? t : m_pc + 32'd4;
            if (c >= TB && c <= TL && c % 4 == 0) m_pc = c;
            else begin m_fault = 1; m_fpc = c; end
        end
    endtask
    task automatic check_model();
        chk("vpc", bus.virtual_pc, m_pc);
        chk("ppc", 32'(bus.physical_pc), (m_pc - TB) % 32'h2000);
        chk("plus4", bus.pc_plus4, m_pc + 32'd4);
        chk("fetch_valid", 32'(bus.fetch_valid), 32'(!m_boot && !m_fault));
        chk("fault", 32'(bus.fault), 32'(m_fault));
        chk("fault_pc", bus.fault_pc, m_fpc);
    endtask
    task automatic cyc(input bit r, input bit s, input bit rv, input logic [31:0] t, input bit rd, input bit cl);
        rst = r; bus.stall = s; bus.redirect_valid = rv; bus.redirect_target = t;
        bus.fetch_ready = rd; bus.fault_clear = cl;
        @(posedge clk);
        model_step(r, s, rv, t, rd, cl);
        #1;
        check_model();
    endtask
    function automatic logic [31:0] rand_target();
        logic [31:0] edges [5];
        edges = '{TB - 32'd4, TL - 32'd3, TL + 32'd1, 32'hffff_fffc, 32'h0};
        case ($urandom_range(0, 3))
            0: return TB + 32'($urandom_range(0, 2047)) * 4;
            1: return $urandom;
            2: return TB + 32'($urandom_range(0, 8191));
            default: return edges[$urandom_range(0, 4)];
        endcase
    endfunction
    initial begin
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_target = 0; bus.fetch_ready = 0; bus.fault_clear = 0;
        // T1..T3 as a vector table: {rst,stall,rv,target,ready,clear} -> {virtual_pc,fetch_valid}
        vt.push_back('{1,0,0,0,1,0, 32'h0040_0000, 0});
        vt.push_back('{0,0,0,0,1,0, 32'h0040_0000, 1});
        vt.push_back('{0,0,0,0,1,0, 32'h0040_0004, 1});
        vt.push_back('{0,0,0,0,1,0, 32'h0040_0008, 1});
        vt.push_back('{0,0,0,0,1,0, 32'h0040_000c, 1});
        vt.push_back('{0,0,0,0,1,0, 32'h0040_0010, 1});
        vt.push_back('{0,1,0,0,1,0, 32'h0040_0010, 1});
        vt.push_back('{0,1,0,0,1,0, 32'h0040_0010, 1});
        vt.push_back('{0,1,0,0,1,0, 32'h0040_0010, 1});
        vt.push_back('{0,0,0,0,1,0, 32'h0040_0014, 1});
        vt.push_back('{0,0,0,0,0,0, 32'h0040_0014, 1});
        vt.push_back('{0,0,1,32'h0040_0020,0,0, 32'h0040_0020, 1});
        vt.push_back('{0,1,1,32'h0040_0100,1,0, 32'h0040_0100, 1});
        foreach (vt[i]) begin
            cyc(vt[i].r, vt[i].s, vt[i].rv, vt[i].t, vt[i].rd, vt[i].cl);
            chk("tbl_vpc", bus.virtual_pc, vt[i].vpc);
            chk("tbl_ppc", 32'(bus.physical_pc), vt[i].vpc - TB);
            chk("tbl_fv", 32'(bus.fetch_valid), 32'(vt[i].fv));
        end
        // T4: accept past the end of the window
        cyc(0,0,1,32'h0040_1ff8,0,0);
        cyc(0,0,0,0,1,0);
        chk("t4_vpc_end", bus.virtual_pc, 32'h0040_1ffc);
        cyc(0,0,0,0,1,0);
        chk("t4_fault", 32'(bus.fault), 1);
        chk("t4_fault_pc", bus.fault_pc, 32'h0040_2000);
        chk("t4_vpc_kept", bus.virtual_pc, 32'h0040_1ffc);
        chk("t4_fv", 32'(bus.fetch_valid), 0);
        cyc(0,0,1,32'h0040_0040,1,0);
        chk("t4_ignore_rv", bus.virtual_pc, 32'h0040_1ffc);
        cyc(0,0,0,0,1,1);
        chk("t4_clr_vpc", bus.virtual_pc, RPC);
        chk("t4_clr_fpc_held", bus.fault_pc, 32'h0040_2000);
        chk("t4_clr_boot_fv", 32'(bus.fetch_valid), 0);
        cyc(0,0,0,0,1,0);
        chk("t4_run_fv", 32'(bus.fetch_valid), 1);
        // T5: out-of-range then unaligned redirects
        cyc(0,0,1,32'h0,1,0);
        chk("t5_zero_fault_pc", bus.fault_pc, 32'h0);
        chk("t5_zero_fault", 32'(bus.fault), 1);
        cyc(0,0,0,0,1,1);
        cyc(0,0,0,0,1,0);
        cyc(0,0,1,32'h0040_0102,1,0);
        chk("t5_unal_fault_pc", bus.fault_pc, 32'h0040_0102);
        chk("t5_unal_vpc", bus.virtual_pc, RPC);
        cyc(0,0,0,0,1,1);
        cyc(0,0,0,0,0,0);
        chk("t5_restart_vpc", bus.virtual_pc, RPC);
        chk("t5_restart_fv", 32'(bus.fetch_valid), 1);
        // T6: reset from FAULT and mid-run after a redirect
        cyc(0,0,1,32'h0050_0000,1,0);
        cyc(1,0,1,32'h0040_0200,1,1);
        chk("t6a_fault", 32'(bus.fault), 0);
        chk("t6a_fpc", bus.fault_pc, 0);
        chk("t6a_fv", 32'(bus.fetch_valid), 0);
        cyc(0,0,1,32'h0040_0300,1,0);
        cyc(0,0,1,32'h0040_0200,1,0);
        chk("t6b_redir", bus.virtual_pc, 32'h0040_0200);
        cyc(1,1,1,32'h0040_0400,1,0);
        chk("t6b_vpc", bus.virtual_pc, RPC);
        chk("t6b_ppc", 32'(bus.physical_pc), 0);
        chk("t6b_fv", 32'(bus.fetch_valid), 0);
        // random stimulus against the model
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                rand_target(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
